// File: rtl/mem_bus_pkg.sv
// rtl/mem_bus_pkg.sv - shared types and default widths for the mem_if bus master
package mem_bus_pkg;

    localparam int MEM_ADDR_W = 8;
    localparam int MEM_DATA_W = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_WR,
        S_WR_GAP,
        S_RD,
        S_RD_GAP,
        S_RSP
    } state_e;

    typedef struct packed {
        logic                  we;
        logic [MEM_ADDR_W-1:0] addr;
        logic [MEM_DATA_W-1:0] wdata;
    } mem_req_t;

endpackage

// File: rtl/mem_req_fifo.sv
// rtl/mem_req_fifo.sv - show-ahead request FIFO; pointers wrap, count is one bit wider
module mem_req_fifo
    import mem_bus_pkg::*;
#(
    parameter type entry_t    = mem_req_t,
    parameter int  FIFO_DEPTH = 4
) (
    input  logic   clk,
    input  logic   rst_n,
    input  logic   push,
    input  entry_t push_data,
    input  logic   pop,
    output entry_t pop_data,
    output logic   full,
    output logic   empty
);

    localparam int PTR_W = $clog2(FIFO_DEPTH);

    entry_t           slots [FIFO_DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W:0]   count;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (PTR_W+1)'(FIFO_DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = slots[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            slots[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/mem_bus_master.sv
// rtl/mem_bus_master.sv - mem_if initiator: queued requests, ce/we timing, read response port
module mem_bus_master
    import mem_bus_pkg::*;
#(
    parameter int ADDR_W     = MEM_ADDR_W,
    parameter int DATA_W     = MEM_DATA_W,
    parameter int FIFO_DEPTH = 4,
    parameter int RD_LAT     = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [ADDR_W-1:0] rsp_addr,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              mem_ce,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_datai,
    input  logic [DATA_W-1:0] mem_datao,
    output logic              busy
);

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
    } req_t;

    localparam int CNT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e           state;
    state_e           state_nxt;
    req_t             push_req;
    req_t             head;
    req_t             cur;
    logic             fifo_full;
    logic             fifo_empty;
    logic             pop;
    logic             rd_last;
    logic [CNT_W-1:0] rd_cnt;

    assign push_req = '{we: req_we, addr: req_addr, wdata: req_wdata};

    mem_req_fifo #(
        .entry_t    (req_t),
        .FIFO_DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (req_valid),
        .push_data (push_req),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign pop     = (state == S_IDLE) && !fifo_empty;
    assign rd_last = (rd_cnt == '0);

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:   if (!fifo_empty) state_nxt = head.we ? S_WR : S_RD;
            S_WR:     state_nxt = S_WR_GAP;
            S_WR_GAP: state_nxt = S_IDLE;
            S_RD:     if (rd_last) state_nxt = S_RD_GAP;
            S_RD_GAP: state_nxt = rsp_ready ? S_IDLE : S_RSP;
            S_RSP:    if (rsp_ready) state_nxt = S_IDLE;
            default:  state_nxt = S_IDLE;
        endcase
    end

    // Bus fields come from the popped entry register, so they only move on the edge where ce rises.
    assign mem_ce    = (state == S_WR) || (state == S_RD);
    assign mem_we    = cur.we;
    assign mem_addr  = cur.addr;
    assign mem_datai = cur.wdata;
    assign rsp_valid = (state == S_RD_GAP) || (state == S_RSP);
    assign req_ready = !fifo_full;
    assign busy      = (state != S_IDLE) || !fifo_empty;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= S_IDLE;
            cur       <= '0;
            rd_cnt    <= '0;
            rsp_addr  <= '0;
            rsp_rdata <= '0;
        end else begin
            state <= state_nxt;
            if (pop) begin
                cur    <= head;
                rd_cnt <= CNT_W'(RD_LAT - 1);
            end else if (state == S_RD && !rd_last) begin
                rd_cnt <= rd_cnt - 1'b1;
            end
            if (state == S_RD && rd_last) begin
                rsp_addr  <= cur.addr;
                rsp_rdata <= mem_datao;
            end
        end
    end

endmodule

// File: tb/tb_mem_bus_master.sv
// tb/tb_mem_bus_master.sv - self-checking bench for mem_bus_master with memory responder and scoreboard
module tb_mem_bus_master;

    localparam int AW     = 8;
    localparam int DW     = 8;
    localparam int RD_LAT = 2;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic [AW-1:0] req_addr = '0;
    logic [DW-1:0] req_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b0;
    logic [AW-1:0] rsp_addr;
    logic [DW-1:0] rsp_rdata;
    logic          mem_ce;
    logic          mem_we;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_datai;
    logic [DW-1:0] mem_datao;
    logic          busy;

    always #5 clk = ~clk;

    mem_bus_master #(
        .ADDR_W     (AW),
        .DATA_W     (DW),
        .FIFO_DEPTH (4),
        .RD_LAT     (RD_LAT)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_addr  (req_addr),
        .req_wdata (req_wdata),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_addr  (rsp_addr),
        .rsp_rdata (rsp_rdata),
        .mem_ce    (mem_ce),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_datai (mem_datai),
        .mem_datao (mem_datao),
        .busy      (busy)
    );

    // Memory responder: read data is only correct once ce has been high RD_LAT-1 earlier cycles.
    logic [DW-1:0] bus_mem [256];
    int            ce_hi = 0;
    always @(posedge clk) begin
        if (mem_ce && mem_we) bus_mem[mem_addr] <= mem_datai;
        ce_hi <= mem_ce ? ce_hi + 1 : 0;
    end
    assign mem_datao = (mem_ce && !mem_we && ce_hi >= RD_LAT - 1) ? bus_mem[mem_addr] : ~bus_mem[mem_addr];

    // Reference model: memory image updated in acceptance order, expected reads queued in order.
    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } exp_t;

    logic [DW-1:0] ref_mem [256];
    exp_t          exp_q [$];
    int            n_checks = 0;
    int            n_pass = 0;
    int            n_rsp = 0;
    logic          rand_rdy = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, want, $time);
    endtask

    logic          p_ce = 1'b0;
    logic          p_we = 1'b0;
    logic [AW-1:0] p_addr = '0;
    logic [DW-1:0] p_datai = '0;
    logic          p_hold = 1'b0;
    logic [AW-1:0] p_raddr = '0;
    logic [DW-1:0] p_rdata = '0;
    int            run = 0;

    always @(negedge clk) begin
        exp_t e;
        if (!reset) begin
            exp_q.delete();
            run    = 0;
            p_hold = 1'b0;
        end else begin
            if (req_valid && req_ready) begin
                if (req_we) ref_mem[req_addr] = req_wdata;
                else exp_q.push_back('{req_addr, ref_mem[req_addr]});
            end
            if (mem_ce && p_ce)
                check("bus_hold_in_access", {mem_we, mem_addr, mem_datai}, {p_we, p_addr, p_datai});
            if (!mem_ce)
                check("bus_stable_when_idle", {mem_we, mem_addr, mem_datai}, {p_we, p_addr, p_datai});
            if (p_ce && !mem_ce)
                check("ce_pulse_len", run, p_we ? 1 : RD_LAT);
            run = mem_ce ? run + 1 : 0;
            if (p_hold) begin
                check("rsp_held_stable", {rsp_valid, rsp_addr, rsp_rdata}, {1'b1, p_raddr, p_rdata});
                check("no_ce_while_stalled", mem_ce, 1'b0);
            end
            if (rsp_valid && rsp_ready) begin
                check("rsp_expected", exp_q.size() > 0, 1'b1);
                if (exp_q.size() > 0) begin
                    e = exp_q.pop_front();
                    check("rsp_addr", rsp_addr, e.addr);
                    check("rsp_rdata", rsp_rdata, e.data);
                end
                n_rsp++;
            end
            p_hold = rsp_valid && !rsp_ready;
        end
        p_ce    = mem_ce;
        p_we    = mem_we;
        p_addr  = mem_addr;
        p_datai = mem_datai;
        p_raddr = rsp_addr;
        p_rdata = rsp_rdata;
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1;
            rsp_ready = ($urandom_range(0, 3) != 0);
        end
    end

    // Called at posedge+1; leaves req_valid high so consecutive calls are back-to-back.
    task automatic send(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int   k = 0;
        logic acc = 1'b0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
        while (!acc && k < 100) begin
            @(negedge clk);
            acc = req_ready;
            k++;
            @(posedge clk);
            #1;
        end
        check("req_accepted", acc, 1'b1);
    endtask

    task automatic wait_idle(input string tag);
        int k = 0;
        while ((busy || exp_q.size() != 0) && k < 300) begin
            @(negedge clk);
            k++;
        end
        check(tag, k < 300, 1'b1);
    endtask

    logic [DW-1:0] wdat [6];
    int            r0;
    int            k;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            bus_mem[i] = '0;
            ref_mem[i] = '0;
        end
        wdat = '{8'hA5, 8'h3C, 8'hFF, 8'h00, 8'h81, 8'h7E};

        // Reset held with a pending request
        req_valid = 1'b1; req_we = 1'b1; req_addr = 8'h10; req_wdata = 8'h77;
        repeat (10) @(posedge clk);
        @(negedge clk);
        check("rst_req_ready", req_ready, 1'b1);
        check("rst_mem_ce", mem_ce, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_busy", busy, 1'b0);
        check("rst_outputs_zero", {mem_we, mem_addr, mem_datai, rsp_addr, rsp_rdata}, '0);
        req_valid = 1'b0;
        @(posedge clk); #1;
        reset = 1'b1;
        @(negedge clk);
        check("rst_no_push", busy, 1'b0);

        // Write burst
        @(posedge clk); #1;
        for (int i = 0; i < 6; i++) send(1'b1, AW'(i), wdat[i]);
        req_valid = 1'b0;
        @(negedge clk);
        check("burst_fifo_full", req_ready, 1'b0);
        rsp_ready = 1'b1;
        wait_idle("burst_drain");
        for (int i = 0; i < 6; i++) check("burst_mem", bus_mem[i], wdat[i]);

        // Read-back with first-response latency
        r0 = n_rsp;
        @(posedge clk); #1;
        fork
            begin
                for (int i = 0; i < 6; i++) send(1'b0, AW'(i), '0);
                req_valid = 1'b0;
            end
            begin
                int lat = 1;
                @(negedge clk);
                while (!rsp_valid && lat < 30) begin
                    @(negedge clk);
                    lat++;
                end
                check("rd_latency", lat, 5);
            end
        join
        wait_idle("readback_drain");
        check("readback_count", n_rsp - r0, 6);

        // Backpressure with a queued write behind the read
        rsp_ready = 1'b0;
        @(posedge clk); #1;
        send(1'b0, 8'd2, '0);
        send(1'b1, 8'd7, 8'h55);
        req_valid = 1'b0;
        k = 0;
        while (!rsp_valid && k < 30) begin
            @(negedge clk);
            k++;
        end
        check("bp_rsp_seen", rsp_valid, 1'b1);
        for (int i = 0; i < 7; i++) begin
            @(negedge clk);
            check("bp_valid", rsp_valid, 1'b1);
            check("bp_rdata", rsp_rdata, 8'hFF);
            check("bp_no_ce", mem_ce, 1'b0);
        end
        check("bp_write_held", bus_mem[7], 8'h00);
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        k = 0;
        while (!(mem_ce && mem_we) && k < 20) begin
            @(negedge clk);
            k++;
        end
        check("bp_write_after", {mem_ce, mem_we, mem_addr, mem_datai}, {1'b1, 1'b1, 8'd7, 8'h55});
        wait_idle("bp_drain");

        // Mixed write/read ordering on one address
        r0 = n_rsp;
        @(posedge clk); #1;
        send(1'b1, 8'd3, 8'h11);
        send(1'b0, 8'd3, '0);
        send(1'b1, 8'd3, 8'h22);
        send(1'b0, 8'd3, '0);
        req_valid = 1'b0;
        wait_idle("mixed_drain");
        check("mixed_count", n_rsp - r0, 2);
        check("mixed_mem", bus_mem[3], 8'h22);

        // Reset during the first read cycle
        r0 = n_rsp;
        @(posedge clk); #1;
        send(1'b0, 8'd4, '0);
        send(1'b0, 8'd5, '0);
        req_valid = 1'b0;
        k = 0;
        while (!mem_ce && k < 20) begin
            @(posedge clk); #2;
            k++;
        end
        check("rstmid_ce_before", {mem_ce, mem_we}, 2'b10);
        reset = 1'b0;
        #1;
        check("rstmid_ce_async", mem_ce, 1'b0);
        check("rstmid_fifo_empty", busy, 1'b0);
        check("rstmid_req_ready", req_ready, 1'b1);
        @(posedge clk); #1;
        reset = 1'b1;
        k = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (rsp_valid || mem_ce) k++;
        end
        check("rstmid_quiet_after", k, 0);
        check("rstmid_no_rsp", n_rsp - r0, 0);

        // Randomized traffic with random response backpressure
        rand_rdy = 1'b1;
        @(posedge clk); #1;
        for (int i = 0; i < 120; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                req_valid = 1'b0;
                @(posedge clk); #1;
            end
            send(1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)), DW'($urandom));
        end
        req_valid = 1'b0;
        rand_rdy  = 1'b0;
        @(posedge clk); #2;
        rsp_ready = 1'b1;
        wait_idle("rand_drain");
        for (int a = 0; a < 16; a++) check("rand_mem", bus_mem[a], ref_mem[a]);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
